arm_mc_controller: RTL and testbench

- Main control state machine for the multicycle ARM datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the immediate-extender select (ImmSrc), the register-address selects and all datapath mux and write-enable strobes.
- Sits between the instruction register output and the datapath. Condition-flag gating of RegW/MemW/Branch is done downstream, not here.

---
 rtl/arm_mc_controller.sv | 165 ++++++++++++++++
 tb/tb_arm_mc_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/arm_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : arm_mc_controller
// Description : Main control FSM for the multicycle ARM datapath. Walks each
//               instruction through fetch / decode / execute / memory /
//               writeback and drives the datapath mux selects and strobes.
//               Condition-flag gating of RegW/MemW/Branch happens downstream.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               Op, Funct       - Instr[27:26] and Instr[25:20]
//               MemReady        - memory access completes when high
//               IRWrite, NextPC, RegW, MemW, Branch - write strobes
//               AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp - datapath selects
//               ImmSrc, RegSrc  - decoded straight from Op (combinational)
//               StateDbg        - current state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module arm_mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               MemReady,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               ALUOp,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [STATE_W-1:0] StateDbg
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        EXECUTEI = STATE_W'(7),
        ALUWB    = STATE_W'(8),
        BRANCH   = STATE_W'(9)
    } state_t;

    state_t state_q;
    state_t state_d;

    // Strobes before reset gating
    logic irwrite_raw;
    logic nextpc_raw;
    logic regw_raw;
    logic memw_raw;
    logic branch_raw;

    // Only I (Funct[5]) and S/L (Funct[0]) steer this controller
    logic unused_funct;
    assign unused_funct = ^Funct[4:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = FETCH;
        irwrite_raw = 1'b0;
        nextpc_raw  = 1'b0;
        regw_raw    = 1'b0;
        memw_raw    = 1'b0;
        branch_raw  = 1'b0;
        AdrSrc      = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUOp       = 1'b0;

        case (state_q)
            FETCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                irwrite_raw = MemReady;
                nextpc_raw  = MemReady;
                state_d     = MemReady ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00:   state_d = Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;   // undefined opcode: silent no-op
                endcase
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = MemReady ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                regw_raw  = 1'b1;
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc   = 1'b1;
                // Write strobe only in the completing cycle, so one pulse per store
                memw_raw = MemReady;
                state_d  = MemReady ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            ALUWB: begin
                regw_raw = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                ALUSrcB    = 2'b01;
                ResultSrc  = 2'b10;
                branch_raw = 1'b1;
                state_d    = FETCH;
            end
            default: begin
                state_d = FETCH;   // unused encodings recover to FETCH
            end
        endcase
    end

    // Reset suppresses every strobe in the same cycle so an abandoned
    // instruction cannot commit anything.
    assign IRWrite = irwrite_raw & ~reset;
    assign NextPC  = nextpc_raw  & ~reset;
    assign RegW    = regw_raw    & ~reset;
    assign MemW    = memw_raw    & ~reset;
    assign Branch  = branch_raw  & ~reset;

    assign ImmSrc   = (Op == 2'b11) ? 2'b00 : Op;
    assign RegSrc   = {(Op == 2'b01), (Op == 2'b10)};
    assign StateDbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_arm_mc_controller
// Description : Directed-vector scoreboard bench for arm_mc_controller. Each
//               cycle the driver pushes the hand-derived expected outputs;
//               a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_mc_controller;

    localparam int STATE_W = 4;

    logic               clk;
    logic               reset;
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic               MemReady;
    logic               IRWrite, NextPC, RegW, MemW, Branch;
    logic               AdrSrc, ALUSrcA, ALUOp;
    logic [1:0]         ALUSrcB, ResultSrc, ImmSrc, RegSrc;
    logic [STATE_W-1:0] StateDbg;

    arm_mc_controller #(.STATE_W(STATE_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .MemReady  (MemReady),
        .IRWrite   (IRWrite),
        .NextPC    (NextPC),
        .RegW      (RegW),
        .MemW      (MemW),
        .Branch    (Branch),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ResultSrc (ResultSrc),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .RegSrc    (RegSrc),
        .StateDbg  (StateDbg)
    );

    // Clock starts high: falling edge (check) precedes each rising edge
    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk_all;   // 0: state unknown, compare strobes only
        logic [3:0] st;
        logic       irw, npc, regw, memw, br;
        logic       adr, asa;
        logic [1:0] asb, rs;
        logic       aop;
        logic [1:0] imm, rsrc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    // Expected outputs for a given (hand-sequenced) state, from the output table
    function automatic exp_t expect_for(int st, bit known, bit rst, bit mr, logic [1:0] op);
        exp_t e;
        e = '0;
        e.chk_all = known;
        e.st      = 4'(st);
        case (st)
            0: begin e.asa = 1; e.asb = 2'b10; e.rs = 2'b10; e.irw = mr; e.npc = mr; end
            1: begin e.asa = 1; e.asb = 2'b10; e.rs = 2'b10; end
            2: begin e.asb = 2'b01; end
            3: begin e.adr = 1; end
            4: begin e.rs = 2'b01; e.regw = 1; end
            5: begin e.adr = 1; e.memw = mr; end
            6: begin e.aop = 1; end
            7: begin e.asb = 2'b01; e.aop = 1; end
            8: begin e.regw = 1; end
            9: begin e.asb = 2'b01; e.rs = 2'b10; e.br = 1; end
            default: ;
        endcase
        if (rst) begin
            e.irw = 0; e.npc = 0; e.regw = 0; e.memw = 0; e.br = 0;
        end
        case (op)
            2'b00: begin e.imm = 2'b00; e.rsrc = 2'b00; end
            2'b01: begin e.imm = 2'b01; e.rsrc = 2'b10; end
            2'b10: begin e.imm = 2'b10; e.rsrc = 2'b01; end
            default: begin e.imm = 2'b00; e.rsrc = 2'b00; end
        endcase
        return e;
    endfunction

    // Apply inputs for one cycle, queue the expectation, advance past the edge
    task automatic step(input string nm, input bit rst, input logic [1:0] op,
                        input logic [5:0] fn, input bit mr, input int st, input bit known);
        reset    = rst;
        Op       = op;
        Funct    = fn;
        MemReady = mr;
        exp_q.push_back(expect_for(st, known, rst, mr, op));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        exp_t  e, a;
        string nm;
        bit    bad;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '0;
                a.chk_all = e.chk_all;
                a.st  = StateDbg;
                a.irw = IRWrite; a.npc = NextPC; a.regw = RegW; a.memw = MemW; a.br = Branch;
                a.adr = AdrSrc;  a.asa = ALUSrcA; a.asb = ALUSrcB; a.rs = ResultSrc;
                a.aop = ALUOp;   a.imm = ImmSrc;  a.rsrc = RegSrc;
                n_vec++;
                if (e.chk_all)
                    bad = (a !== e);
                else
                    bad = ({a.irw, a.npc, a.regw, a.memw, a.br} !== {e.irw, e.npc, e.regw, e.memw, e.br});
                if (bad) begin
                    n_fail++;
                    $display("FAIL %s vec%0d: got st=%0d irw/npc/regw/memw/br=%b%b%b%b%b adr=%b asa=%b asb=%b rs=%b aop=%b imm=%b rsrc=%b ; expected st=%0d irw/npc/regw/memw/br=%b%b%b%b%b adr=%b asa=%b asb=%b rs=%b aop=%b imm=%b rsrc=%b",
                             nm, n_vec, a.st, a.irw, a.npc, a.regw, a.memw, a.br, a.adr, a.asa, a.asb, a.rs, a.aop, a.imm, a.rsrc,
                             e.st, e.irw, e.npc, e.regw, e.memw, e.br, e.adr, e.asa, e.asb, e.rs, e.aop, e.imm, e.rsrc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, expected run to complete", n_vec);
        $fatal(1);
    end

    // Stimulus: hand-sequenced state traces
    initial begin
        reset = 1'b1; Op = 2'b00; Funct = 6'b0; MemReady = 1'b1;

        // Reset held three cycles; state unknown before the first edge
        step("rst0", 1, 2'b00, 6'b001000, 1, 0, 0);
        step("rst1", 1, 2'b00, 6'b001000, 1, 0, 1);
        step("rst2", 1, 2'b00, 6'b001000, 1, 0, 1);

        // Data-processing register: 0,1,6,8
        step("dpr_fetch",  0, 2'b00, 6'b001000, 1, 0, 1);
        step("dpr_decode", 0, 2'b00, 6'b001000, 1, 1, 1);
        step("dpr_exec",   0, 2'b00, 6'b001000, 1, 6, 1);
        step("dpr_wb",     0, 2'b00, 6'b001000, 1, 8, 1);

        // Load with two wait cycles in MEMREAD: 0,1,2,3,3,3,4
        step("ld_fetch",  0, 2'b01, 6'b011001, 1, 0, 1);
        step("ld_decode", 0, 2'b01, 6'b011001, 1, 1, 1);
        step("ld_adr",    0, 2'b01, 6'b011001, 1, 2, 1);
        step("ld_wait1",  0, 2'b01, 6'b011001, 0, 3, 1);
        step("ld_wait2",  0, 2'b01, 6'b011001, 0, 3, 1);
        step("ld_read",   0, 2'b01, 6'b011001, 1, 3, 1);
        step("ld_wb",     0, 2'b01, 6'b011001, 1, 4, 1);

        // Store with a fetch stall: 0,0,1,2,5
        step("st_stall",  0, 2'b01, 6'b011000, 0, 0, 1);
        step("st_fetch",  0, 2'b01, 6'b011000, 1, 0, 1);
        step("st_decode", 0, 2'b01, 6'b011000, 1, 1, 1);
        step("st_adr",    0, 2'b01, 6'b011000, 1, 2, 1);
        step("st_write",  0, 2'b01, 6'b011000, 1, 5, 1);

        // Branch: 0,1,9
        step("br_fetch",  0, 2'b10, 6'b100000, 1, 0, 1);
        step("br_decode", 0, 2'b10, 6'b100000, 1, 1, 1);
        step("br_branch", 0, 2'b10, 6'b100000, 1, 9, 1);

        // Undefined opcode: 0,1 then straight back to FETCH
        step("ud_fetch",  0, 2'b11, 6'b111111, 1, 0, 1);
        step("ud_decode", 0, 2'b11, 6'b111111, 1, 1, 1);

        // Data-processing immediate: 0,1,7,8
        step("dpi_fetch",  0, 2'b00, 6'b101001, 1, 0, 1);
        step("dpi_decode", 0, 2'b00, 6'b101001, 1, 1, 1);
        step("dpi_exec",   0, 2'b00, 6'b101001, 1, 7, 1);
        step("dpi_wb",     0, 2'b00, 6'b101001, 1, 8, 1);

        // Store with a wait in MEMWRITE: MemW only in the completing cycle
        step("stw_fetch",  0, 2'b01, 6'b010000, 1, 0, 1);
        step("stw_decode", 0, 2'b01, 6'b010000, 1, 1, 1);
        step("stw_adr",    0, 2'b01, 6'b010000, 1, 2, 1);
        step("stw_wait",   0, 2'b01, 6'b010000, 0, 5, 1);
        step("stw_write",  0, 2'b01, 6'b010000, 1, 5, 1);

        // Reset in MEMWRITE with MemReady=1: no MemW, back to FETCH
        step("rm_fetch",  0, 2'b01, 6'b011000, 1, 0, 1);
        step("rm_decode", 0, 2'b01, 6'b011000, 1, 1, 1);
        step("rm_adr",    0, 2'b01, 6'b011000, 1, 2, 1);
        step("rm_reset",  1, 2'b01, 6'b011000, 1, 5, 1);
        step("rm_after",  0, 2'b00, 6'b000000, 1, 0, 1);
        step("rm_decode2",0, 2'b00, 6'b000000, 1, 1, 1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
